// File: rtl/sti_dac_pkg.sv
// Shared types, default sizes and frame builder for the serial DAC engine.
// Holds FSM state codes and the byte-window / zero-extend helper.
package sti_dac_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_MAX_BYTES  = 4;
  localparam int DEF_NUM_BANKS  = 8;
  localparam int DEF_BANK_DEPTH = 32;
  localparam int DEF_ROW_BYTES  = 8;

  localparam int LEN_W  = $clog2(DEF_MAX_BYTES);
  localparam int ADDR_W = $clog2(DEF_BANK_DEPTH);
  localparam int CNT_W  =
    $clog2(DEF_NUM_BANKS * DEF_BANK_DEPTH) + 1;

  localparam int FB_W = 256;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_FILL  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Result is right-aligned: the frame occupies bits [8*nbytes-1:0].
  function automatic logic [FB_W-1:0] build_frame(
    input logic [FB_W-1:0] data,
    input int              dw,
    input int              nbytes,
    input logic            low,
    input logic            fill
  );
    logic [FB_W-1:0] m;
    logic [FB_W-1:0] f;
    int              nb;
    nb = nbytes * 8;
    m  = '1;
    m  = m >> (FB_W - nb);
    f  = data;
    if (nb < dw) begin
      f = low ? (data >> (dw - nb)) : (data & m);
    end else if (nb > dw && fill) begin
      f = data << (nb - dw);
    end
    return f;
  endfunction

endpackage

// File: rtl/sti_oem_map.sv
// Byte-index to bank/address mapper with checkerboard row interleave.
// Ports: b (byte index) -> wr (one-hot bank strobe), addr (bank address).
module sti_oem_map
  import sti_dac_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int ROW_BYTES  = DEF_ROW_BYTES,
  parameter int CW         =
    $clog2(NUM_BANKS * BANK_DEPTH) + 1
) (
  input  logic [CW-1:0]                 b,
  output logic [NUM_BANKS-1:0]          wr,
  output logic [$clog2(BANK_DEPTH)-1:0] addr
);

  localparam int AW     = $clog2(BANK_DEPTH);
  localparam int GRP_SH = $clog2(2 * BANK_DEPTH);
  localparam int ROW_SH = $clog2(ROW_BYTES);

  int   g;
  int   idx;
  logic p;

  always_comb begin
    g    = int'(b >> GRP_SH);
    p    = b[0] ^ b[ROW_SH];
    addr = AW'(b >> 1);
    idx  = p ? (NUM_BANKS / 2 + g) : g;
    wr   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      wr[i] = (i == idx);
    end
  end

endmodule

// File: rtl/sti_dac_gen.sv
// Serial transmit engine with byte scatter into odd/even memory banks.
// Ports: load/pi_* frame in, so_* serial out, oem_* bank writes + flags.
module sti_dac_gen
  import sti_dac_pkg::*;
#(
  parameter int         DATA_W     = DEF_DATA_W,
  parameter int         MAX_BYTES  = DEF_MAX_BYTES,
  parameter int         NUM_BANKS  = DEF_NUM_BANKS,
  parameter int         BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int         ROW_BYTES  = DEF_ROW_BYTES,
  parameter logic [7:0] FILL_BYTE  = 8'h00
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  output logic                          pi_ready,
  input  logic                          pi_end,
  input  logic [DATA_W-1:0]             pi_data,
  input  logic [$clog2(MAX_BYTES)-1:0]  pi_length,
  input  logic                          pi_msb,
  input  logic                          pi_low,
  input  logic                          pi_fill,
  input  logic                          so_ready,
  output logic                          so_data,
  output logic                          so_valid,
  output logic [NUM_BANKS-1:0]          oem_wr,
  output logic [$clog2(BANK_DEPTH)-1:0] oem_addr,
  output logic [7:0]                    oem_dataout,
  output logic                          oem_ovf,
  output logic                          oem_finish
);

  localparam int AW    = $clog2(BANK_DEPTH);
  localparam int TOTAL = NUM_BANKS * BANK_DEPTH;
  localparam int CW    = $clog2(TOTAL) + 1;
  localparam int FW    = 8 * MAX_BYTES;
  localparam int BLW   = $clog2(FW) + 1;

  state_t         state;
  logic [FW-1:0]  sh;
  logic [FW-1:0]  fr_c;
  logic           msb_q;
  logic [BLW-1:0] bits_left;
  logic [6:0]     byte_sr;
  logic [CW-1:0]  b;
  logic           full;
  int             lb;

  logic [NUM_BANKS-1:0] map_wr;
  logic [AW-1:0]        map_addr;

  sti_oem_map #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_DEPTH(BANK_DEPTH),
    .ROW_BYTES (ROW_BYTES),
    .CW        (CW)
  ) u_map (
    .b   (b),
    .wr  (map_wr),
    .addr(map_addr)
  );

  assign pi_ready = (state == ST_IDLE);
  assign so_valid = (state == ST_SHIFT);
  assign full     = (b == CW'(TOTAL));

  // MSB-first frames are left-aligned so the live bit is always sh[FW-1].
  always_comb begin
    lb   = int'(pi_length) + 1;
    fr_c = FW'(build_frame(FB_W'(pi_data), DATA_W,
                           lb, pi_low, pi_fill));
    if (pi_msb) begin
      fr_c = fr_c << (FW - 8 * lb);
    end
  end

  always_comb begin
    so_data = 1'b0;
    if (state == ST_SHIFT) begin
      so_data = msb_q ? sh[FW-1] : sh[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sh          <= '0;
      msb_q       <= 1'b0;
      bits_left   <= '0;
      byte_sr     <= '0;
      b           <= '0;
      oem_wr      <= '0;
      oem_addr    <= '0;
      oem_dataout <= '0;
      oem_ovf     <= 1'b0;
      oem_finish  <= 1'b0;
    end else begin
      oem_wr <= '0;
      if (state == ST_DONE) begin
        oem_finish <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pi_end) begin
            state <= full ? ST_DONE : ST_FILL;
          end else if (load) begin
            sh        <= fr_c;
            msb_q     <= pi_msb;
            bits_left <= BLW'(8 * lb);
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (so_ready) begin
            sh        <= msb_q ? (sh << 1) : (sh >> 1);
            byte_sr   <= {byte_sr[5:0], so_data};
            bits_left <= bits_left - BLW'(1);
            // Frames are whole bytes, so bit count mod 8 marks byte ends.
            if (bits_left[2:0] == 3'd1) begin
              if (full) begin
                oem_ovf <= 1'b1;
              end else begin
                oem_wr      <= map_wr;
                oem_addr    <= map_addr;
                oem_dataout <= {byte_sr, so_data};
                b           <= b + CW'(1);
              end
            end
            if (bits_left == BLW'(1)) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_FILL: begin
          oem_wr      <= map_wr;
          oem_addr    <= map_addr;
          oem_dataout <= FILL_BYTE;
          b           <= b + CW'(1);
          if (b == CW'(TOTAL - 1)) begin
            state <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sti_dac_gen.sv
// Scoreboard bench for sti_dac_gen at default parameters.
// Stimulus pushes expected bits/writes; a negedge monitor pops them.
module tb_sti_dac_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        pi_ready;
  logic        pi_end;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_msb;
  logic        pi_low;
  logic        pi_fill;
  logic        so_ready;
  logic        so_data;
  logic        so_valid;
  logic [7:0]  oem_wr;
  logic [4:0]  oem_addr;
  logic [7:0]  oem_dataout;
  logic        oem_ovf;
  logic        oem_finish;

  sti_dac_gen dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .pi_ready   (pi_ready),
    .pi_end     (pi_end),
    .pi_data    (pi_data),
    .pi_length  (pi_length),
    .pi_msb     (pi_msb),
    .pi_low     (pi_low),
    .pi_fill    (pi_fill),
    .so_ready   (so_ready),
    .so_data    (so_data),
    .so_valid   (so_valid),
    .oem_wr     (oem_wr),
    .oem_addr   (oem_addr),
    .oem_dataout(oem_dataout),
    .oem_ovf    (oem_ovf),
    .oem_finish (oem_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         bank;
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_wr[$];
  logic exp_bit[$];
  int   checks   = 0;
  int   failures = 0;
  int   obs_n    = 0;
  int   obs_bank[300];
  int   obs_addr[300];
  int   bits_acc = 0;
  int   tb_b     = 0;
  int   m_idx;
  logic m_e;
  wr_t  m_w;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int eb(input int bi);
    int g;
    int p;
    g = bi / 64;
    p = (bi % 2) ^ ((bi / 8) % 2);
    return (p != 0) ? 4 + g : g;
  endfunction

  function automatic int ea(input int bi);
    return (bi % 64) / 2;
  endfunction

  always @(negedge clk) begin
    if (!reset && so_valid && so_ready) begin
      bits_acc++;
      if (exp_bit.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        m_e = exp_bit.pop_front();
        chk("so_data", int'(so_data), int'(m_e));
      end
    end
    if (oem_wr != 8'h00) begin
      m_idx = -1;
      for (int i = 0; i < 8; i++) if (oem_wr[i]) m_idx = i;
      chk("wr_onehot", $countones(oem_wr), 1);
      if (obs_n < 300) begin
        obs_bank[obs_n] = m_idx;
        obs_addr[obs_n] = int'(oem_addr);
      end
      obs_n++;
      if (exp_wr.size() == 0) begin
        chk("unexpected_wr", 1, 0);
      end else begin
        m_w = exp_wr.pop_front();
        chk("wr_bank", m_idx, m_w.bank);
        chk("wr_addr", int'(oem_addr), m_w.addr);
        chk("wr_data", int'(oem_dataout), int'(m_w.data));
      end
    end
  end

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bit.push_back(v[i]);
  endtask

  task automatic push_wr(input int bk, input int ad, input logic [7:0] d);
    wr_t w;
    w.bank = bk;
    w.addr = ad;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_msb(input logic [31:0] fr, input int nbytes);
    logic [7:0] by;
    for (int i = 0; i < nbytes; i++) begin
      by = fr[8*(nbytes-1-i) +: 8];
      push_bits({24'h0, by}, 8);
      if (tb_b < 256) push_wr(eb(tb_b), ea(tb_b), by);
      tb_b++;
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_so_data", int'(so_data), 0);
    chk("rst_so_valid", int'(so_valid), 0);
    chk("rst_oem_wr", int'(oem_wr), 0);
    chk("rst_oem_addr", int'(oem_addr), 0);
    chk("rst_oem_dataout", int'(oem_dataout), 0);
    chk("rst_oem_ovf", int'(oem_ovf), 0);
    chk("rst_oem_finish", int'(oem_finish), 0);
    chk("rst_pi_ready", int'(pi_ready), 1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    load     = 1'b0;
    pi_end   = 1'b0;
    so_ready = 1'b1;
    #3;
    check_reset_vals();
    @(posedge clk);
    #1;
    exp_bit.delete();
    exp_wr.delete();
    obs_n = 0;
    tb_b  = 0;
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!pi_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!pi_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] len,
                       input logic msb, input logic low,
                       input logic fill);
    wait_ready();
    pi_data   = d;
    pi_length = len;
    pi_msb    = msb;
    pi_low    = low;
    pi_fill   = fill;
    load      = 1'b1;
    @(posedge clk);
    #1;
    load    = 1'b0;
    pi_data = ~d;
    pi_msb  = ~msb;
    pi_low  = ~low;
    pi_fill = ~fill;
    chk("so_valid_after_load", int'(so_valid), 1);
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] len,
                      input logic msb, input logic low,
                      input logic fill, output int lat);
    drive(d, len, msb, low, fill);
    lat = 0;
    while (!pi_ready && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    chk("bits_left_over", exp_bit.size(), 0);
    chk("wr_left_over", exp_wr.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   bits0;
    int   n;
    logic [15:0] d;
    load      = 1'b0;
    pi_end    = 1'b0;
    pi_data   = '0;
    pi_length = '0;
    pi_msb    = 1'b0;
    pi_low    = 1'b0;
    pi_fill   = 1'b0;
    so_ready  = 1'b1;
    reset     = 1'b1;
    #2;

    do_reset();
    push_bits(32'hA5, 8);
    push_wr(0, 0, 8'hA5);
    tb_b = 1;
    send(16'hA53C, 2'd0, 1'b1, 1'b1, 1'b0, lat);
    chk("lat_L1", lat, 8);
    drain();

    do_reset();
    push_bits(32'h002C48, 24);
    push_wr(0, 0, 8'h00);
    push_wr(4, 0, 8'h2C);
    push_wr(0, 1, 8'h48);
    tb_b = 3;
    send(16'h1234, 2'd2, 1'b0, 1'b0, 1'b1, lat);
    chk("lat_L3", lat, 24);
    drain();

    push_msb(32'hD35A, 2);
    drive(16'hD35A, 2'd1, 1'b1, 1'b0, 1'b0);
    bits0 = bits_acc;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    so_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_data", int'(so_data), 1);
      chk("stall_valid", int'(so_valid), 1);
      chk("stall_no_wr", int'(oem_wr), 0);
    end
    @(posedge clk);
    #1;
    so_ready = 1'b1;
    wait_ready();
    drain();
    chk("stall_bits", bits_acc - bits0, 16);
    chk("stall_map_bank", obs_bank[3], 4);
    chk("stall_map_addr", obs_addr[3], 1);

    do_reset();
    push_msb(32'h00ABCD, 3);
    send(16'hABCD, 2'd2, 1'b1, 1'b0, 1'b0, lat);
    for (int i = 3; i < 256; i++) push_wr(eb(i), ea(i), 8'h00);
    pi_end = 1'b1;
    @(posedge clk);
    #1;
    pi_end = 1'b0;
    n = 0;
    while (!(oem_wr[3] && oem_addr == 5'd31) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("fill_last_seen", int'(oem_wr[3] && oem_addr == 5'd31), 1);
    chk("finish_on_last_wr", int'(oem_finish), 0);
    @(negedge clk);
    chk("finish_next", int'(oem_finish), 1);
    chk("done_ready", int'(pi_ready), 0);
    load = 1'b1;
    repeat (5) @(negedge clk);
    load = 1'b0;
    chk("finish_sticky", int'(oem_finish), 1);
    chk("done_no_shift", int'(so_valid), 0);
    chk("fill_writes", obs_n - 3, 253);
    drain();

    do_reset();
    for (int i = 0; i < 65; i++) begin
      d = 16'(i * 16'h0111 + 1);
      if (i == 64) chk("ovf_before", int'(oem_ovf), 0);
      push_msb({16'h0, d}, 4);
      send(d, 2'd3, 1'b1, 1'b0, 1'b0, lat);
    end
    drain();
    chk("ovf_set", int'(oem_ovf), 1);
    chk("ovf_writes", obs_n, 256);
    chk("map8_bank", obs_bank[8], 4);
    chk("map8_addr", obs_addr[8], 4);
    chk("map9_bank", obs_bank[9], 0);
    chk("map9_addr", obs_addr[9], 4);
    chk("map64_bank", obs_bank[64], 1);
    chk("map64_addr", obs_addr[64], 0);
    pi_end = 1'b1;
    @(posedge clk);
    #1;
    pi_end = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_end_finish", int'(oem_finish), 1);
    chk("full_end_ready", int'(pi_ready), 0);
    chk("full_end_no_wr", obs_n, 256);
    chk("ovf_sticky", int'(oem_ovf), 1);

    do_reset();
    push_msb(32'h96F0, 2);
    drive(16'h96F0, 2'd1, 1'b1, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("mid_valid", int'(so_valid), 1);
    chk("mid_dataout", int'(oem_dataout), 8'h96);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals();
    exp_bit.delete();
    exp_wr.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", int'(pi_ready), 1);
    chk("post_rst_valid", int'(so_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
